// File: rtl/osd_line_renderer.sv
// OSD line renderer: executes a per-line rectangle list into ping-pong line buffers
// and streams finished lines out over AXI-Stream while the next line renders.
module osd_line_renderer #(
  parameter int unsigned H_ACTIVE = 320,
  parameter int unsigned V_ACTIVE = 240,
  parameter int unsigned PIX_W    = 16,
  parameter int unsigned INST_AW  = 9
) (
  input  logic               hclk,
  input  logic               hreset,
  input  logic               gen_en,
  input  logic [PIX_W-1:0]   bg_color,
  output logic [INST_AW-1:0] inst_addr,
  input  logic [31:0]        inst_data,
  output logic [PIX_W-1:0]   tdata_m,
  output logic               tvalid_m,
  input  logic               tready_m,
  output logic               tlast_m,
  output logic               tuser_m,
  output logic               busy,
  output logic               list_err
);

  localparam int unsigned XW = 12;
  localparam int unsigned HW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam logic [XW-1:0]      H_LIM    = XW'(H_ACTIVE);
  localparam logic [XW-1:0]      H_LAST_X = XW'(H_ACTIVE - 1);
  localparam logic [HW-1:0]      H_LAST   = HW'(H_ACTIVE - 1);
  localparam logic [XW-1:0]      V_LAST   = XW'(V_ACTIVE - 1);
  localparam logic [INST_AW-1:0] PC_LIM   = INST_AW'((2 ** INST_AW) - 3);

  typedef enum logic [2:0] {IDLE, CLEAR, FETCH0, FETCH1, FETCH2, DRAW, READY} state_t;

  state_t             state_q;
  logic [XW-1:0]      y_q, x_q, xend_q, x0_q, x1_q, y0_q, y1_q;
  logic [3:0]         bw_q;
  logic               fill_q, f2_q, rsel_q, err_q, busy_q;
  logic [PIX_W-1:0]   col_q;
  logic [INST_AW-1:0] pc_q, addr_q;

  logic               s_act_q, sline0_q, slast_q, olast_line_q;
  logic [HW-1:0]      sx_q;
  logic [PIX_W-1:0]   tdata_q;
  logic               tvalid_q, tlast_q, tuser_q;

  logic [PIX_W-1:0] buf0 [0:H_ACTIVE-1];
  logic [PIX_W-1:0] buf1 [0:H_ACTIVE-1];

  logic [2:0]       op;
  logic [XW-1:0]    w_lo, w_hi, bw_x, x1_clip;
  logic             hit, r_we, clr_both, s_we, draw_done;
  logic [HW-1:0]    r_idx;
  logic [PIX_W-1:0] r_dat, s_rd;
  logic             unused_bits;

  assign op          = inst_data[26:24];
  assign w_lo        = inst_data[11:0];
  assign w_hi        = inst_data[23:12];
  assign unused_bits = ^inst_data[31:29];
  assign x1_clip     = (w_hi > H_LIM) ? H_LIM : w_hi;
  assign bw_x        = {8'b0, bw_q};

  assign hit = fill_q
            || ((x_q - x0_q) < bw_x)
            || ((x1_q - XW'(1) - x_q) < bw_x)
            || ((y_q - y0_q) < bw_x)
            || ((y1_q - XW'(1) - y_q) < bw_x);

  assign draw_done = (x_q >= xend_q) || ((x_q + XW'(1)) == xend_q);
  assign s_we      = s_act_q && (!tvalid_q || tready_m);
  assign s_rd      = rsel_q ? buf0[sx_q] : buf1[sx_q];

  // CLEAR paints both buffers so the line after the first never shows stale content.
  always_comb begin
    r_we     = 1'b0;
    clr_both = 1'b0;
    r_idx    = x_q[HW-1:0];
    r_dat    = col_q;
    if (state_q == CLEAR) begin
      r_we     = 1'b1;
      clr_both = 1'b1;
      r_dat    = bg_color;
    end else if (state_q == DRAW && x_q < xend_q && hit) begin
      r_we = 1'b1;
    end
  end

  always_ff @(posedge hclk) begin
    if (r_we && (!rsel_q || clr_both)) buf0[r_idx] <= r_dat;
    else if (s_we && rsel_q)           buf0[sx_q]  <= bg_color;
  end

  always_ff @(posedge hclk) begin
    if (r_we && (rsel_q || clr_both)) buf1[r_idx] <= r_dat;
    else if (s_we && !rsel_q)         buf1[sx_q]  <= bg_color;
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q      <= IDLE;
      y_q          <= '0;
      x_q          <= '0;
      xend_q       <= '0;
      x0_q         <= '0;
      x1_q         <= '0;
      y0_q         <= '0;
      y1_q         <= '0;
      bw_q         <= '0;
      fill_q       <= 1'b0;
      f2_q         <= 1'b0;
      col_q        <= '0;
      pc_q         <= '0;
      addr_q       <= '0;
      rsel_q       <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      s_act_q      <= 1'b0;
      sline0_q     <= 1'b0;
      slast_q      <= 1'b0;
      olast_line_q <= 1'b0;
      sx_q         <= '0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tuser_q      <= 1'b0;
    end else begin
      // Stream side: load a beat whenever the output register is free or draining.
      if (s_we) begin
        tdata_q      <= s_rd;
        tvalid_q     <= 1'b1;
        tlast_q      <= (sx_q == H_LAST);
        tuser_q      <= sline0_q && (sx_q == '0);
        olast_line_q <= slast_q;
        sx_q         <= sx_q + HW'(1);
        if (sx_q == H_LAST) s_act_q <= 1'b0;
      end else if (tvalid_q && tready_m) begin
        tvalid_q <= 1'b0;
      end

      if (state_q == IDLE && tvalid_q && tready_m && tlast_q && olast_line_q)
        busy_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (gen_en && !s_act_q) begin
            state_q <= CLEAR;
            x_q     <= '0;
            y_q     <= '0;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          x_q <= x_q + XW'(1);
          if (x_q == H_LAST_X) begin
            state_q <= FETCH0;
            pc_q    <= '0;
            addr_q  <= '0;
          end
        end
        FETCH0: begin
          addr_q  <= pc_q + INST_AW'(1);
          state_q <= FETCH1;
        end
        FETCH1: begin
          // A non-END word that would run into the last address terminates the list.
          if (op == 3'b111) begin
            state_q <= READY;
          end else if (pc_q >= PC_LIM) begin
            err_q   <= 1'b1;
            state_q <= READY;
          end else if (op == 3'b000 && y_q >= w_lo && y_q < w_hi) begin
            y0_q    <= w_lo;
            y1_q    <= w_hi;
            addr_q  <= pc_q + INST_AW'(2);
            f2_q    <= 1'b0;
            state_q <= FETCH2;
          end else begin
            pc_q    <= pc_q + INST_AW'(3);
            addr_q  <= pc_q + INST_AW'(3);
            state_q <= FETCH0;
          end
        end
        FETCH2: begin
          if (!f2_q) begin
            x0_q   <= w_lo;
            x1_q   <= w_hi;
            x_q    <= w_lo;
            xend_q <= x1_clip;
            bw_q   <= inst_data[27:24];
            fill_q <= inst_data[28];
            f2_q   <= 1'b1;
          end else begin
            col_q   <= inst_data[PIX_W-1:0];
            f2_q    <= 1'b0;
            state_q <= DRAW;
          end
        end
        DRAW: begin
          if (draw_done) begin
            pc_q    <= pc_q + INST_AW'(3);
            addr_q  <= pc_q + INST_AW'(3);
            state_q <= FETCH0;
          end else begin
            x_q <= x_q + XW'(1);
          end
        end
        READY: begin
          if (!s_act_q) begin
            rsel_q   <= ~rsel_q;
            s_act_q  <= 1'b1;
            sx_q     <= '0;
            sline0_q <= (y_q == '0);
            slast_q  <= (y_q == V_LAST);
            y_q      <= (y_q == V_LAST) ? '0 : y_q + XW'(1);
            pc_q     <= '0;
            addr_q   <= '0;
            state_q  <= (y_q == V_LAST && !gen_en) ? IDLE : FETCH0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign inst_addr = addr_q;
  assign tdata_m   = tdata_q;
  assign tvalid_m  = tvalid_q;
  assign tlast_m   = tlast_q;
  assign tuser_m   = tuser_q;
  assign busy      = busy_q;
  assign list_err  = err_q;

endmodule
